// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
// Module   : writeback
// Purpose  : Pipeline writeback stage: ALU/load register writes, load data
//            extraction with timeout, retire counter. Optional bypass port
//            enabled by macro WB_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module writeback #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_result,
  input  logic        wb_mem_write,
  input  logic        wb_alu_to_reg,
  input  logic        wb_mem_to_reg,
  input  logic [4:0]  wb_dest_reg_sel,
  input  logic        wb_branch,
  input  logic [1:0]  wb_read_address,
  input  logic [2:0]  mem_alu_operation,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        stall_read,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        load_misaligned,
  output logic        bus_error,
  output logic [31:0] instret,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [31:0]        rf_wdata_q, rf_wdata_d;
  logic               misal_q, misal_d;
  logic               bus_err_q, bus_err_d;
  logic [31:0]        instret_q, instret_d;

  logic        kill;
  logic        is_byte, is_half, is_word, sign_ext;
  logic        misal_cond, live_load;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic        done_load, done_alu, done_store, abort, stall;
  logic        wr_any;
  logic [31:0] wr_data;

  always_comb begin
    kill     = wb_branch;
    is_byte  = (mem_alu_operation == 3'b000) || (mem_alu_operation == 3'b100);
    is_half  = (mem_alu_operation == 3'b001) || (mem_alu_operation == 3'b101);
    // Every other code, including the undefined ones, behaves as LW.
    is_word  = !is_byte && !is_half;
    sign_ext = !mem_alu_operation[2];

    misal_cond = wb_mem_to_reg && !kill &&
                 ((is_half && wb_read_address[0]) ||
                  (is_word && (wb_read_address != 2'b00)));
    live_load  = wb_mem_to_reg && !kill && !misal_cond;

    case (wb_read_address)
      2'd0:    sel_byte = dmem_rdata[7:0];
      2'd1:    sel_byte = dmem_rdata[15:8];
      2'd2:    sel_byte = dmem_rdata[23:16];
      default: sel_byte = dmem_rdata[31:24];
    endcase
    sel_half = wb_read_address[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    if (is_byte)
      load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
    else if (is_half)
      load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
    else
      load_data = dmem_rdata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_load  = 1'b0;
    done_alu   = 1'b0;
    done_store = 1'b0;
    abort      = 1'b0;
    stall      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (live_load) begin
          if (dmem_rvalid) begin
            done_load = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end else if (wb_alu_to_reg && !wb_mem_to_reg && !kill) begin
          done_alu = 1'b1;
        end else if (wb_mem_write && !wb_mem_to_reg && !kill) begin
          done_store = 1'b1;
        end
      end
      S_WAIT: begin
        if (!live_load) begin
          state_d = S_IDLE;
        end else if (dmem_rvalid) begin
          done_load = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == C_CNT_LAST) begin
          // Stall drops here so the aborted load drains instead of reissuing.
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_any     = done_load || done_alu;
    wr_data    = done_load ? load_data : wb_result;
    rf_we_d    = wr_any && (wb_dest_reg_sel != 5'd0);
    rf_waddr_d = rf_we_d ? wb_dest_reg_sel : 5'd0;
    rf_wdata_d = rf_we_d ? wr_data : 32'd0;
    misal_d    = (state_q == S_IDLE) && misal_cond;
    bus_err_d  = abort;
    instret_d  = instret_q + {31'd0, (done_load || done_alu || done_store)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      misal_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      instret_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      misal_q    <= misal_d;
      bus_err_q  <= bus_err_d;
      instret_q  <= instret_d;
    end
  end

  assign stall_read      = stall && reset;
  assign rf_we           = rf_we_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign load_misaligned = misal_q;
  assign bus_error       = bus_err_q;
  assign instret         = instret_q;

`ifdef WB_FORWARD_EN
  assign fwd_valid = rf_we_d;
  assign fwd_reg   = rf_waddr_d;
  assign fwd_data  = rf_wdata_d;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback
// Purpose  : Directed self-checking bench for writeback (TIMEOUT_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback;

  logic        clk;
  logic        reset;
  logic [31:0] wb_result;
  logic        wb_mem_write, wb_alu_to_reg, wb_mem_to_reg, wb_branch;
  logic [4:0]  wb_dest_reg_sel;
  logic [1:0]  wb_read_address;
  logic [2:0]  mem_alu_operation;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        stall_read, rf_we, load_misaligned, bus_error, fwd_valid;
  logic [4:0]  rf_waddr, fwd_reg;
  logic [31:0] rf_wdata, instret, fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .wb_result(wb_result), .wb_mem_write(wb_mem_write),
    .wb_alu_to_reg(wb_alu_to_reg), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_dest_reg_sel(wb_dest_reg_sel), .wb_branch(wb_branch),
    .wb_read_address(wb_read_address), .mem_alu_operation(mem_alu_operation),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .stall_read(stall_read), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .load_misaligned(load_misaligned),
    .bus_error(bus_error), .instret(instret),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_result         = 32'd0;
    wb_mem_write      = 1'b0;
    wb_alu_to_reg     = 1'b0;
    wb_mem_to_reg     = 1'b0;
    wb_dest_reg_sel   = 5'd0;
    wb_branch         = 1'b0;
    wb_read_address   = 2'd0;
    mem_alu_operation = 3'b010;
    dmem_rdata        = 32'd0;
    dmem_rvalid       = 1'b0;
  endtask

  task automatic set_load(input logic [2:0] f3, input logic [1:0] off,
                          input logic [4:0] dest, input logic [31:0] rdata,
                          input logic rvalid);
    idle_inputs();
    wb_mem_to_reg     = 1'b1;
    mem_alu_operation = f3;
    wb_read_address   = off;
    wb_dest_reg_sel   = dest;
    dmem_rdata        = rdata;
    dmem_rvalid       = rvalid;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    // Live-looking load during reset must not stall.
    set_load(3'b010, 2'd0, 5'd3, 32'd0, 1'b0);
    #1;
    check_eq("rst_stall", {31'd0, stall_read}, 32'd0);
    step();
    check_eq("rst_we", {31'd0, rf_we}, 32'd0);
    check_eq("rst_wdata", rf_wdata, 32'd0);
    check_eq("rst_instret", instret, 32'd0);
    check_eq("rst_err", {30'd0, bus_error, load_misaligned}, 32'd0);
    idle_inputs();
    step();
    reset = 1'b1;
    step();

    // ALU write
    wb_alu_to_reg = 1'b1; wb_dest_reg_sel = 5'd5; wb_result = 32'h1234;
    #1;
`ifdef WB_FORWARD_EN
    check_eq("fwd_valid", {31'd0, fwd_valid}, 32'd1);
    check_eq("fwd_data", fwd_data, 32'h1234);
`else
    check_eq("fwd_off", {26'd0, fwd_valid, fwd_reg}, 32'd0);
    check_eq("fwd_off_data", fwd_data, 32'd0);
`endif
    step();
    check_eq("alu_we", {31'd0, rf_we}, 32'd1);
    check_eq("alu_waddr", {27'd0, rf_waddr}, 32'd5);
    check_eq("alu_wdata", rf_wdata, 32'h1234);
    check_eq("alu_instret", instret, 32'd1);

    // LB offset 3, immediate data
    set_load(3'b000, 2'd3, 5'd6, 32'h80FF_FFFF, 1'b1);
    #1;
    check_eq("lb_stall", {31'd0, stall_read}, 32'd0);
    step();
    check_eq("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    check_eq("lb_waddr", {27'd0, rf_waddr}, 32'd6);
    check_eq("lb_instret", instret, 32'd2);

    // LHU offset 2, three cycles without rvalid
    set_load(3'b101, 2'd2, 5'd7, 32'hBEEF_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("lhu_stall%0d", i), {31'd0, stall_read}, 32'd1);
      step();
      check_eq($sformatf("lhu_nowe%0d", i), {31'd0, rf_we}, 32'd0);
    end
    dmem_rvalid = 1'b1;
    #1;
    check_eq("lhu_stall_done", {31'd0, stall_read}, 32'd0);
    step();
    check_eq("lhu_wdata", rf_wdata, 32'h0000_BEEF);
    check_eq("lhu_instret", instret, 32'd3);

    // LW timeout: stall for the IDLE cycle plus three wait cycles, abort on the fourth
    set_load(3'b010, 2'd0, 5'd8, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("to_stall%0d", i), {31'd0, stall_read},
               (i < 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("to_noerr%0d", i), {31'd0, bus_error}, 32'd0);
      step();
    end
    check_eq("to_bus_error", {31'd0, bus_error}, 32'd1);
    check_eq("to_we", {31'd0, rf_we}, 32'd0);
    check_eq("to_instret", instret, 32'd3);
    idle_inputs();
    step();
    check_eq("to_pulse_end", {31'd0, bus_error}, 32'd0);

    // Misaligned LW
    set_load(3'b010, 2'd1, 5'd9, 32'h1111_2222, 1'b0);
    #1;
    check_eq("mis_stall", {31'd0, stall_read}, 32'd0);
    step();
    check_eq("mis_pulse", {31'd0, load_misaligned}, 32'd1);
    check_eq("mis_we", {31'd0, rf_we}, 32'd0);
    check_eq("mis_instret", instret, 32'd3);

    // ALU to x0
    idle_inputs();
    wb_alu_to_reg = 1'b1; wb_dest_reg_sel = 5'd0; wb_result = 32'h55;
    step();
    check_eq("x0_we", {31'd0, rf_we}, 32'd0);
    check_eq("x0_instret", instret, 32'd4);
    check_eq("mis_pulse_end", {31'd0, load_misaligned}, 32'd0);

    // Killed ALU op
    wb_dest_reg_sel = 5'd7; wb_branch = 1'b1;
    step();
    check_eq("kill_we", {31'd0, rf_we}, 32'd0);
    check_eq("kill_instret", instret, 32'd4);

    // Store
    idle_inputs();
    wb_mem_write = 1'b1;
    #1;
    check_eq("st_stall", {31'd0, stall_read}, 32'd0);
    step();
    check_eq("st_we", {31'd0, rf_we}, 32'd0);
    check_eq("st_instret", instret, 32'd5);

    // LH sign extension
    set_load(3'b001, 2'd0, 5'd10, 32'h0000_8001, 1'b1);
    step();
    check_eq("lh_wdata", rf_wdata, 32'hFFFF_8001);

    // Undefined funct3 acts as LW
    set_load(3'b110, 2'd0, 5'd11, 32'hCAFE_F00D, 1'b1);
    step();
    check_eq("undef_wdata", rf_wdata, 32'hCAFE_F00D);

    // Load wins over ALU when both are set (LBU offset 1)
    set_load(3'b100, 2'd1, 5'd12, 32'h0000_A500, 1'b1);
    wb_alu_to_reg = 1'b1; wb_result = 32'h7777;
    step();
    check_eq("prio_wdata", rf_wdata, 32'h0000_00A5);
    check_eq("prio_instret", instret, 32'd8);

    // Reset while waiting
    set_load(3'b010, 2'd0, 5'd13, 32'h0, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("rw_stall", {31'd0, stall_read}, 32'd0);
    check_eq("rw_outs", {30'd0, rf_we, bus_error}, 32'd0);
    check_eq("rw_instret", instret, 32'd0);
    idle_inputs();
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("rw_noerr%0d", i), {30'd0, bus_error, rf_we}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent waiting for dmem_rvalid before a load is aborted.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 wb_result  input  32  ALU result, or load address for loads.
REQ-005 wb_mem_write  input  1  store in the WB slot; no register write.
REQ-006 wb_alu_to_reg  input  1  write wb_result to the register file.
REQ-007 wb_mem_to_reg  input  1  load; write extracted memory data.
REQ-008 wb_dest_reg_sel  input  5  destination register.
REQ-009 wb_branch  input  1  instruction in the WB slot is squashed.
REQ-010 wb_read_address  input  2  load byte offset.
REQ-011 mem_alu_operation  input  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 dmem_rdata  input  32  data memory read word.
REQ-013 dmem_rvalid  input  1  dmem_rdata valid this cycle.
REQ-014 stall_read  output  1  holds the execute stage; EX/WB inputs stay stable while high.
REQ-015 rf_we / rf_waddr / rf_wdata  output  1/5/32  registered register-file write port.
REQ-016 load_misaligned / bus_error  output  1/1  single-cycle registered error pulses.
REQ-017 instret  output  32  retired-instruction counter.
REQ-018 fwd_valid / fwd_reg / fwd_data  output  1/5/32  combinational bypass of the next write (see Configuration).

Function
REQ-019 Define kill = wb_branch; a killed slot causes no write, no stall, no error and no retire.
REQ-020 FSM states: IDLE and WAIT.
REQ-021 In IDLE, a live load with dmem_rvalid=1 is completed in the same cycle.
REQ-022 In IDLE, a live load with dmem_rvalid=0 moves to WAIT and clears the wait counter.
REQ-023 In WAIT, dmem_rvalid=1 completes the load and returns to IDLE.
REQ-024 In WAIT, when the counter reaches TIMEOUT_CYCLES-1 without rvalid: abort the load, pulse bus_error, perform no write, return to IDLE.
REQ-025 stall_read = live load & ~dmem_rvalid, in IDLE or WAIT; it is combinational and is low in the completing cycle.
REQ-026 A live load has wb_mem_to_reg=1, kill=0 and is aligned; when both wb_mem_to_reg and wb_alu_to_reg are high, the load takes priority.
REQ-027 Misalignment: LH/LHU with offset[0]=1, or LW with offset!=0, pulses load_misaligned next cycle, with no write, no stall and no retire.
REQ-028 Load extraction selects a byte/halfword by offset, then sign-extends (LB/LH) or zero-extends (LBU/LHU); LW passes the word.
REQ-029 rf_we/rf_waddr/rf_wdata update one edge after completion (latency 1).
REQ-030 rf_we is 0 when wb_dest_reg_sel=0.
REQ-031 An ALU write completes in IDLE in its first cycle.
REQ-032 instret increments once per completed non-killed ALU op, load or store, and wraps from FFFFFFFF to 0.
REQ-033 Stores retire without a write and without a stall.
REQ-034 Undefined mem_alu_operation codes (011, 11x) are treated as LW.

Reset
REQ-035 While reset=0: state=IDLE, wait counter=0, instret=0, and rf_we, rf_waddr, rf_wdata, load_misaligned and bus_error are 0.
REQ-036 An assertion of reset while in WAIT aborts the load with no write and no error pulse.
REQ-037 stall_read is 0 while reset=0.

Configuration
REQ-038 Macro WB_FORWARD_EN defined: fwd_valid/fwd_reg/fwd_data equal the pre-register values of rf_we/rf_waddr/rf_wdata.
REQ-039 Macro WB_FORWARD_EN undefined: fwd_valid, fwd_reg and fwd_data are tied to 0 and no bypass logic is present.

Verification
REQ-040 ALU: wb_alu_to_reg=1, dest=5, result=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, instret=1.
REQ-041 LB: offset=3, rdata=0x80FFFFFF, rvalid=1 -> rf_wdata=0xFFFFFF80, stall_read never high.
REQ-042 LHU: offset=2, rvalid low 3 cycles then high with rdata=0xBEEF0000 -> stall_read high 3 cycles, then rf_wdata=0x0000BEEF.
REQ-043 LW: rvalid never arrives, TIMEOUT_CYCLES=4 -> bus_error pulse after 4 wait cycles, rf_we=0, state returns to IDLE.
REQ-044 Corner cases: LW offset=1 -> load_misaligned pulse, no write; dest=0 -> rf_we=0; wb_branch=1 -> no write and instret unchanged.
REQ-045 Reset and forwarding: reset asserted in WAIT -> all outputs 0; with WB_FORWARD_EN, fwd_data equals rf_wdata one cycle early.
